fetch_unit: RTL and testbench

//  Instruction-fetch stage of the 32-bit CPU, directly upstream of instruction_memory.

---
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control inputs from hazard/execute, the instruction-memory port and the
// IF/ID register outputs, all bundled for the fetch unit.
//   master : the fetch unit (drives imem_addr and the IF/ID outputs)
//   slave  : the surroundings (memory, hazard unit, execute, decode)
// Signals:
//   stall, redirect_valid, redirect_target : hold / execute redirect requests
//   imem_addr, imem_data                   : instruction-memory address and returned word
//   ifid_instr, ifid_pc, ifid_valid        : IF/ID register contents
//   ifid_jump_taken                        : IF/ID instruction is a JUMP fetch already followed
//   fetch_err, fetch_count                 : sticky range error and delivered-instruction count
interface fetch_unit_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic        ifid_jump_taken;
  logic        fetch_err;
  logic [31:0] fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_target, imem_data,
    output imem_addr, ifid_instr, ifid_pc, ifid_valid, ifid_jump_taken, fetch_err, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_target, imem_data,
    input  imem_addr, ifid_instr, ifid_pc, ifid_valid, ifid_jump_taken, fetch_err, fetch_count
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Holds the word-addressed PC, presents it to instruction memory and
// latches the returned word into the IF/ID register. Supports hazard stall, execute redirect,
// an optional early JUMP redirect and a sticky halt when the PC leaves the legal range.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : fetch_unit_if.master (see fetch_unit_if.sv for the signal list)
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] MAX_ADDR   = 32'h0000_001A,
  parameter bit          EARLY_JUMP = 1'b1,
  parameter logic [5:0]  JUMP_OP    = 6'b010101
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic        jump_q, jump_d;
  logic        err_q, err_d;
  logic [31:0] count_q, count_d;

  logic        is_jump;

  assign is_jump = EARLY_JUMP && (bus.imem_data[31:26] == JUMP_OP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      ipc_q   <= 32'h0;
      valid_q <= 1'b0;
      jump_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      jump_q  <= jump_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    jump_d  = jump_q;
    err_d   = err_q;
    count_d = count_q;

    unique case (state_q)
      // One dead cycle after reset so the memory output settles before first capture.
      StIdle: begin
        valid_d = 1'b0;
        state_d = StFetch;
      end
      StFetch: begin
        if (bus.redirect_valid) begin
          // Redirect beats stall; an illegal target is caught on the next edge.
          pc_d    = bus.redirect_target;
          valid_d = 1'b0;
          jump_d  = 1'b0;
        end else if (pc_q > MAX_ADDR) begin
          state_d = StHalt;
          err_d   = 1'b1;
          valid_d = 1'b0;
        end else if (!bus.stall) begin
          instr_d = bus.imem_data;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          count_d = count_q + 32'd1;
          if (is_jump) begin
            pc_d   = {6'b0, bus.imem_data[25:0]};
            jump_d = 1'b1;
          end else begin
            pc_d   = pc_q + 32'd1;
            jump_d = 1'b0;
          end
        end
      end
      StHalt: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.imem_addr       = pc_q;
  assign bus.ifid_instr      = instr_q;
  assign bus.ifid_pc         = ipc_q;
  assign bus.ifid_valid      = valid_q;
  assign bus.ifid_jump_taken = jump_q;
  assign bus.fetch_err       = err_q;
  assign bus.fetch_count     = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (early JUMP on / off) share memory and stimulus. A
// directed opening walks the basic scenarios, then random stall/redirect/reset traffic is
// compared every cycle against a behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam logic [5:0] JOP  = 6'b010101;
  localparam int unsigned LAST = 26;

  typedef struct {
    int          phase;  // 0 idle, 1 fetching, 2 halted
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] cnt;
    bit          valid;
    bit          jt;
    bit          err;
  } model_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        rv = 1'b0;
  logic [31:0] rt = 32'h0;
  logic [31:0] mem [0:26];
  int          mem_gen = 0;
  int          total = 0;
  int          bad = 0;
  model_t      ma, mb;

  always #5 clk = ~clk;

  fetch_unit_if a_if ();
  fetch_unit_if b_if ();

  fetch_unit #(.EARLY_JUMP(1'b1)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  fetch_unit #(.EARLY_JUMP(1'b0)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  assign a_if.stall           = stall;
  assign a_if.redirect_valid  = rv;
  assign a_if.redirect_target = rt;
  assign b_if.stall           = stall;
  assign b_if.redirect_valid  = rv;
  assign b_if.redirect_target = rt;

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    if (addr <= LAST) return mem[addr[4:0]];
    return 32'h0;
  endfunction

  always @(a_if.imem_addr or mem_gen) a_if.imem_data = word_at(a_if.imem_addr);
  always @(b_if.imem_addr or mem_gen) b_if.imem_data = word_at(b_if.imem_addr);

  function automatic logic [31:0] plain_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == JOP) w[31] = ~w[31];
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic model_t model_step(input model_t m, input bit early, input bit rn,
                                        input bit st, input bit r, input logic [31:0] tgt);
    model_t      n;
    logic [31:0] w;
    n = m;
    if (!rn) begin
      n.phase = 0; n.pc = 32'h0; n.instr = 32'h0; n.ipc = 32'h0; n.cnt = 32'h0;
      n.valid = 0; n.jt = 0; n.err = 0;
      return n;
    end
    if (m.phase == 0) begin
      n.phase = 1;
    end else if (m.phase == 1) begin
      if (r) begin
        n.pc = tgt; n.valid = 0; n.jt = 0;
      end else if (m.pc > LAST) begin
        n.phase = 2; n.err = 1; n.valid = 0;
      end else if (!st) begin
        w = word_at(m.pc);
        n.instr = w; n.ipc = m.pc; n.valid = 1; n.cnt = m.cnt + 1;
        if (early && w[31:26] == JOP) begin
          n.pc = {6'b0, w[25:0]}; n.jt = 1;
        end else begin
          n.pc = m.pc + 1; n.jt = 0;
        end
      end
    end
    return n;
  endfunction

  task automatic cmp_dut(input string n, input model_t m, input logic [31:0] addr,
                         input logic [31:0] instr, input logic [31:0] ipc, input logic valid,
                         input logic jt, input logic err, input logic [31:0] cnt);
    check({n, "_addr"}, addr, m.pc);
    check({n, "_valid"}, {31'b0, valid}, {31'b0, m.valid});
    check({n, "_err"}, {31'b0, err}, {31'b0, m.err});
    check({n, "_cnt"}, cnt, m.cnt);
    check({n, "_jt"}, {31'b0, jt}, {31'b0, m.jt});
    check({n, "_ipc"}, ipc, m.ipc);
    check({n, "_instr"}, instr, m.instr);
  endtask

  // One clock: models advance on the same inputs the DUTs saw, outputs compared mid-cycle.
  task automatic step();
    @(posedge clk);
    ma = model_step(ma, 1'b1, rst_n, stall, rv, rt);
    mb = model_step(mb, 1'b0, rst_n, stall, rv, rt);
    @(negedge clk);
    cmp_dut("a", ma, a_if.imem_addr, a_if.ifid_instr, a_if.ifid_pc, a_if.ifid_valid,
            a_if.ifid_jump_taken, a_if.fetch_err, a_if.fetch_count);
    cmp_dut("b", mb, b_if.imem_addr, b_if.ifid_instr, b_if.ifid_pc, b_if.ifid_valid,
            b_if.ifid_jump_taken, b_if.fetch_err, b_if.fetch_count);
  endtask

  initial begin
    for (int i = 0; i <= int'(LAST); i++) mem[i] = plain_word();
    mem[0] = 32'h0022_0820;  // ADD
    mem[1] = 32'h0400_0822;  // SUB
    mem[2] = 32'h2021_0005;  // ADDI
    mem[4] = {JOP, 26'hD};
    mem_gen++;

    rst_n = 1'b0;
    step();
    step();
    check("rst_valid", {31'b0, a_if.ifid_valid}, 32'd0);
    check("rst_cnt", a_if.fetch_count, 32'd0);
    check("rst_addr", a_if.imem_addr, 32'd0);

    rst_n = 1'b1;
    step();
    check("idle_valid", {31'b0, a_if.ifid_valid}, 32'd0);
    check("idle_addr", a_if.imem_addr, 32'd0);
    step();
    check("t1_pc0", a_if.ifid_pc, 32'd0);
    check("t1_valid", {31'b0, a_if.ifid_valid}, 32'd1);
    check("t1_add", a_if.ifid_instr, 32'h0022_0820);
    step();
    check("t1_pc1", a_if.ifid_pc, 32'd1);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_hold_pc", a_if.ifid_pc, 32'd1);
      check("t2_addr", a_if.imem_addr, 32'd2);
      check("t2_cnt", a_if.fetch_count, 32'd2);
    end
    stall = 1'b0;
    step();
    check("t1_pc2", a_if.ifid_pc, 32'd2);
    check("t1_cnt3", a_if.fetch_count, 32'd3);
    check("t1_addi", a_if.ifid_instr, 32'h2021_0005);

    step();
    step();
    check("t4_jpc", a_if.ifid_pc, 32'd4);
    check("t4_jt", {31'b0, a_if.ifid_jump_taken}, 32'd1);
    check("t4_addr_a", a_if.imem_addr, 32'd13);
    check("t4_addr_b", b_if.imem_addr, 32'd5);
    check("t4_jt_b", {31'b0, b_if.ifid_jump_taken}, 32'd0);
    step();
    check("t4_next_a", a_if.ifid_pc, 32'd13);
    check("t4_nobubble", {31'b0, a_if.ifid_valid}, 32'd1);
    check("t4_next_b", b_if.ifid_pc, 32'd5);

    stall = 1'b1; rv = 1'b1; rt = 32'd5;
    step();
    check("t3_flush", {31'b0, a_if.ifid_valid}, 32'd0);
    check("t3_addr", a_if.imem_addr, 32'd5);
    stall = 1'b0; rv = 1'b0;
    step();
    check("t3_pc5", a_if.ifid_pc, 32'd5);

    for (int i = 0; i < 40; i++) begin
      if (a_if.imem_addr == 32'd27) break;
      step();
    end
    check("t5_reach", a_if.imem_addr, 32'd27);
    step();
    check("t5_err", {31'b0, a_if.fetch_err}, 32'd1);
    check("t5_valid", {31'b0, a_if.ifid_valid}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      stall = 1'($urandom_range(0, 1));
      rv = 1'b1;
      rt = 32'd3;
      step();
      check("t5_stuck_addr", a_if.imem_addr, 32'd27);
      check("t5_stuck_err", {31'b0, a_if.fetch_err}, 32'd1);
      check("t5_stuck_valid", {31'b0, a_if.ifid_valid}, 32'd0);
    end
    stall = 1'b0; rv = 1'b0; rst_n = 1'b0;
    step();
    check("t5_rst_err", {31'b0, a_if.fetch_err}, 32'd0);
    check("t5_rst_cnt", a_if.fetch_count, 32'd0);
    check("t5_rst_addr", a_if.imem_addr, 32'd0);
    check("t5_rst_instr", a_if.ifid_instr, 32'd0);
    rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 99) >= 3);
      if (!rst_n) begin
        for (int k = 0; k < 3; k++) begin
          if ($urandom_range(0, 1) == 0) mem[$urandom_range(0, 26)] =
              {JOP, 26'($urandom_range(0, 28))};
          else mem[$urandom_range(0, 26)] = plain_word();
        end
        mem_gen++;
      end
      stall = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 9) == 0);
      rt = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 28));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
